// File: rtl/ula_multiciclo.sv
// Iterative multiply/divide unit: one radix-2 step per clock, start/busy/done handshake.
// Optional build macro MULT_EARLY_TERM_EN: MUL stops once the remaining multiplier bits are zero.
module ula_multiciclo #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inicio,
  input  logic [1:0]       operacao,
  input  logic [WIDTH-1:0] dado_um,
  input  logic [WIDTH-1:0] dado_dois,
  input  logic [3:0]       cpsr_atual,
  output logic [WIDTH-1:0] resultado,
  output logic [3:0]       out_cpsr,
  output logic             ocupado,
  output logic             pronto,
  output logic             reg_write
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_SDIV = 2'b10;
  localparam logic [1:0] OP_UMOD = 2'b11;

  typedef enum logic [1:0] {OCIOSO, CALCULA, FINAL} estado_t;

  estado_t          state_q, state_d;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;      // multiplicand, or dividend shifting into quotient
  logic [WIDTH-1:0] b_q;      // multiplier, or divisor
  logic [WIDTH-1:0] acc_q;    // product, or partial remainder
  logic             neg_q;
  logic [1:0]       cv_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] resultado_q;
  logic [3:0]       cpsr_q;

  logic             is_div, div_zero, last_step, done_step;
  logic [WIDTH-1:0] mul_acc_n, div_rem_n, div_quo_n, result_n;
  logic [WIDTH:0]   rem_sh, rem_sub;
  logic             q_bit;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic             unused_nz;

  assign unused_nz = ^cpsr_atual[3:2];

  always_comb begin
    abs_a = dado_um[WIDTH-1]   ? ('0 - dado_um)   : dado_um;
    abs_b = dado_dois[WIDTH-1] ? ('0 - dado_dois) : dado_dois;
  end

  always_comb begin
    is_div    = (op_q != OP_MUL);
    div_zero  = is_div && (b_q == '0);
    mul_acc_n = b_q[0] ? (acc_q + a_q) : acc_q;
    rem_sh    = {acc_q, a_q[WIDTH-1]};
    rem_sub   = rem_sh - {1'b0, b_q};
    q_bit     = ~rem_sub[WIDTH];
    div_rem_n = q_bit ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    div_quo_n = {a_q[WIDTH-2:0], q_bit};
`ifdef MULT_EARLY_TERM_EN
    last_step = (cnt_q == CW'(WIDTH - 1)) || (!is_div && (b_q[WIDTH-1:1] == '0));
`else
    last_step = (cnt_q == CW'(WIDTH - 1));
`endif
    done_step = (state_q == CALCULA) && (div_zero || last_step);
  end

  // Final result is formed from the step being taken on the edge that enters FINAL.
  always_comb begin
    result_n = '0;
    case (op_q)
      OP_MUL:  result_n = mul_acc_n;
      OP_SDIV: result_n = div_zero ? '0 : (neg_q ? ('0 - div_quo_n) : div_quo_n);
      OP_UMOD: result_n = div_zero ? a_q : div_rem_n;
      default: result_n = div_zero ? '0 : div_quo_n;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= OCIOSO;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      OCIOSO:  if (inicio) state_d = CALCULA;
      CALCULA: if (done_step) state_d = FINAL;
      FINAL:   state_d = OCIOSO;
      default: state_d = OCIOSO;
    endcase
  end

  always_comb begin
    ocupado   = (state_q == CALCULA);
    pronto    = (state_q == FINAL);
    reg_write = (state_q == FINAL);
    resultado = resultado_q;
    out_cpsr  = cpsr_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      neg_q       <= 1'b0;
      cv_q        <= '0;
      cnt_q       <= '0;
      resultado_q <= '0;
      cpsr_q      <= '0;
    end else begin
      case (state_q)
        OCIOSO: begin
          if (inicio) begin
            op_q  <= operacao;
            cv_q  <= cpsr_atual[1:0];
            cnt_q <= '0;
            acc_q <= '0;
            if (operacao == OP_SDIV) begin
              a_q   <= abs_a;
              b_q   <= abs_b;
              neg_q <= dado_um[WIDTH-1] ^ dado_dois[WIDTH-1];
            end else begin
              a_q   <= dado_um;
              b_q   <= dado_dois;
              neg_q <= 1'b0;
            end
          end
        end
        CALCULA: begin
          cnt_q <= cnt_q + CW'(1);
          if (is_div) begin
            acc_q <= div_rem_n;
            a_q   <= div_quo_n;
          end else begin
            acc_q <= mul_acc_n;
            a_q   <= a_q << 1;
            b_q   <= b_q >> 1;
          end
          if (done_step) begin
            resultado_q <= result_n;
            cpsr_q      <= {result_n[WIDTH-1], (result_n == '0), cv_q};
          end
        end
        default: ;
      endcase
    end
  end

endmodule
